xadac_exe_arb: RTL and testbench
================================

Name: xadac_exe_arb

Overview:
- Round-robin arbiter that shares one xadac execution unit (e.g. the vector MACC unit) between NumReq execute-request streams.
- Forwards the granted request to the unit.
- Records the grant order in an order FIFO and routes each unit response back to the requester that issued it.
- Sits between the xadac execute-stage masters and a single shared xadac execution-unit slave.

Parameters:
- NumReq, 2, number of requesters (2..8).
- ReqWidth, 128, flattened execute-request payload width (id, instr, vs_data).
- RspWidth, 128, flattened execute-response payload width (id, vd_addr, vd_data, vd_write).
- Depth, 4, order-FIFO depth = max outstanding requests (power of 2, >=2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NumReq  per-requester request valid
- req_ready  out  NumReq  per-requester request ready
- req_data  in  NumReq*ReqWidth  request payloads, requester i at [i*ReqWidth +: ReqWidth]
- rsp_valid  out  NumReq  per-requester response valid
- rsp_ready  in  NumReq  per-requester response ready
- rsp_data  out  RspWidth  response payload, broadcast to all requesters
- exe_req_valid  out  1  request valid to shared unit
- exe_req_ready  in  1  shared unit accepts request
- exe_req_data  out  ReqWidth  granted payload
- exe_rsp_valid  in  1  unit response valid
- exe_rsp_ready  out  1  response accepted
- exe_rsp_data  in  RspWidth  unit response payload
- outstanding  out  $clog2(Depth)+1  order-FIFO occupancy
- err  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock clk; reset rstn is asynchronous, active-low. Reset values:
  - rr pointer=0, lock=0, FIFO empty, outstanding=0, err=0.
  - All valid/ready outputs follow from that combinationally; with no req_valid asserted, they are all 0.
- Arbitration (combinational):
  - grant = first i with req_valid[i], searching from rr pointer upward with wrap modulo NumReq.
  - If lock=1, grant = locked index.
- Request path, zero latency:
  - exe_req_valid = any req_valid & !full.
  - exe_req_data = req_data[grant].
  - req_ready[i] = (i==grant) & exe_req_ready & !full; all others 0.
- Stability: if exe_req_valid & !exe_req_ready, set lock=1 with the index held, so the grant cannot switch mid-handshake; clear lock on handshake.
- Requester obligation: a requester must hold valid/data until ready.
- Rotation: on request handshake, rr pointer <= grant+1 (wrap to 0 after NumReq-1). It is unchanged otherwise.
- Order FIFO: on request handshake, push grant index. full means outstanding==Depth; while full, no requests are accepted.
- Response routing:
  - route = FIFO head if not empty.
  - If empty and exe_req_valid, route = grant. This bypass serves single-cycle combinational units whose response arrives in the same cycle as the request.
  - rsp_valid[route] = exe_rsp_valid; others 0.
  - rsp_data = exe_rsp_data.
  - exe_rsp_ready = rsp_ready[route].
- Pop on response handshake:
  - FIFO non-empty: pop the head.
  - Bypass cycle: that cycle's request and response handshakes are both complete; nothing is pushed and nothing is popped.
- Simultaneous push and pop with FIFO non-empty: occupancy is unchanged and pointers advance.
- No combinational path from any rsp_ready to any req_ready other than through exe_req_ready inside the unit.
- Errors:
  - err sets when exe_rsp_valid=1 while FIFO empty and exe_req_valid=0 (orphan response). err stays set until reset.
  - An orphan response is not acknowledged: exe_rsp_ready=0.
- Wrap-around: FIFO read/write pointers are $clog2(Depth) bits with an extra wrap bit for full/empty.
- Reset mid-operation:
  - All outstanding order entries are discarded and lock is cleared.
  - Responses arriving after reset without a matching request raise err.

Test Plan:
- Both requesters valid continuously, unit ready every cycle with combinational response -> grants alternate 0,1,0,1. Each rsp_valid[i] pulses in the same cycle as its req_ready[i]. outstanding stays 0.
- Requester 0 valid, exe_req_ready low for 3 cycles while requester 1 raises valid -> grant stays 0 (lock) until handshake; requester 1 is granted next cycle.
- Unit with 2-cycle response latency, Depth=4, 5 back-to-back requests from requester 1 -> 4 accepted, outstanding=4, req_ready=0 until first response pops. Responses route to requester 1 in order.
- Interleaved requests 0,1,1,0 to a latency-3 unit; rsp_ready[1] held low 2 cycles -> exe_rsp_ready=0 during stall. Delivery order 0,1,1,0 with no lost or duplicated response.
- exe_rsp_valid asserted with FIFO empty and no request -> err=1 next cycle, exe_rsp_ready=0. err stays 1 until rstn pulses low.
- Assert rstn low with outstanding=3 -> outstanding=0, lock=0 and rr pointer=0 immediately (asynchronous). The first request after release is granted to the lowest valid index.

Source files
------------

// File: rtl/xadac_exe_arb.sv
// Round-robin arbiter sharing one xadac execution unit between NumReq execute
// streams; an order FIFO of grant indices routes each response back to its issuer.
module xadac_exe_arb #(
    parameter int NumReq   = 2,
    parameter int ReqWidth = 128,
    parameter int RspWidth = 128,
    parameter int Depth    = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NumReq-1:0]          req_valid,
    output logic [NumReq-1:0]          req_ready,
    input  logic [NumReq*ReqWidth-1:0] req_data,
    output logic [NumReq-1:0]          rsp_valid,
    input  logic [NumReq-1:0]          rsp_ready,
    output logic [RspWidth-1:0]        rsp_data,
    output logic                       exe_req_valid,
    input  logic                       exe_req_ready,
    output logic [ReqWidth-1:0]        exe_req_data,
    input  logic                       exe_rsp_valid,
    output logic                       exe_rsp_ready,
    input  logic [RspWidth-1:0]        exe_rsp_data,
    output logic [$clog2(Depth):0]     outstanding,
    output logic                       err
);
    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = $clog2(Depth);

    // Handshakes are valid/ready: a transfer happens in the cycle where both are
    // high; a requester holds valid and data stable until it sees ready.

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0] order_q [Depth];

    logic [IdxW-1:0] rr_grant, grant, head, route;
    logic            full, empty, route_ok, bypass;
    logic            req_hs, rsp_hs, push, pop;

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] base,
                                                 input int unsigned ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= unsigned'(NumReq)) sum = sum - unsigned'(NumReq);
        return sum[IdxW-1:0];
    endfunction

    // Scan downward so the valid requester closest to the pointer wins last.
    always_comb begin
        rr_grant = rr_q;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid[wrap_inc(rr_q, k)]) rr_grant = wrap_inc(rr_q, k);
        end
    end

    assign grant = lock_q ? lock_idx_q : rr_grant;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign exe_req_valid = (|req_valid) & ~full;
    assign exe_req_data  = req_data[int'(grant)*ReqWidth +: ReqWidth];

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = exe_req_valid & exe_req_ready;
    end

    // With the FIFO empty, a same-cycle response belongs to the request in flight.
    assign head     = order_q[rd_ptr_q[PtrW-1:0]];
    assign bypass   = empty & exe_req_valid;
    assign route_ok = ~empty | exe_req_valid;
    assign route    = empty ? grant : head;

    always_comb begin
        rsp_valid        = '0;
        rsp_valid[route] = exe_rsp_valid & route_ok;
    end

    assign rsp_data      = exe_rsp_data;
    assign exe_rsp_ready = route_ok & rsp_ready[route];

    assign req_hs = exe_req_valid & exe_req_ready;
    assign rsp_hs = exe_rsp_valid & exe_rsp_ready;
    assign push   = req_hs & ~(bypass & rsp_hs);
    assign pop    = rsp_hs & ~empty;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (req_hs) begin
            rr_d   = wrap_inc(grant, 1);
            lock_d = 1'b0;
        end else if (exe_req_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        wr_ptr_d = wr_ptr_q + (PtrW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(pop);
        err_d    = err_q | (exe_rsp_valid & empty & ~exe_req_valid);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) order_q[wr_ptr_q[PtrW-1:0]] <= grant;
    end

    assign outstanding = wr_ptr_q - rd_ptr_q;
    assign err         = err_q;

endmodule

// File: tb/tb_xadac_exe_arb.sv
// Randomised bench for xadac_exe_arb: requester drivers, a behavioural unit model
// with configurable latency, a transaction-level reference model and a scoreboard.
module tb_xadac_exe_arb;
    localparam int N     = 3;
    localparam int RW    = 16;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int OW    = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*RW-1:0] req_data;
    logic [SW-1:0]   rsp_data, exe_rsp_data;
    logic            exe_req_valid, exe_req_ready, exe_rsp_valid, exe_rsp_ready, err;
    logic [RW-1:0]   exe_req_data;
    logic [OW-1:0]   outstanding;

    xadac_exe_arb #(.NumReq(N), .ReqWidth(RW), .RspWidth(SW), .Depth(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .exe_req_valid(exe_req_valid), .exe_req_ready(exe_req_ready),
        .exe_req_data(exe_req_data),
        .exe_rsp_valid(exe_rsp_valid), .exe_rsp_ready(exe_rsp_ready),
        .exe_rsp_data(exe_rsp_data),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            m_rr;
    bit            m_locked;
    int            m_lock_idx;
    int            m_order[$];
    bit            m_err;
    // scoreboard: {requester, response payload} in expected delivery order
    logic [IW+SW-1:0] exp_q[$];
    // execution-unit model
    logic [SW-1:0] unit_q[$];
    int            unit_due[$];
    // requester drivers and knobs
    logic [N-1:0]  r_valid;
    logic [RW-1:0] r_data[N];
    int            seq, cyc, lat, req_pct, rdy_pct, rsp_pct;
    logic [N-1:0]  req_en;
    bit            comb, orphan;
    int            grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] rsp_of(input logic [RW-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'hA5C3;
    endfunction

    function automatic bit busy();
        return (r_valid != '0) || (unit_q.size() != 0) || (exp_q.size() != 0) ||
               (m_order.size() != 0);
    endfunction

    task automatic run_cycle();
        int g, route, pre_n;
        bit found, full_e, vld_e, route_ok, req_hs, rsp_hs, bypass;
        logic [N-1:0] oh;
        logic [IW+SW-1:0] got, want;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!r_valid[i] && req_en[i] && $urandom_range(99) < req_pct) begin
                seq = seq + 1;
                r_valid[i] = 1'b1;
                r_data[i]  = {2'(i), 14'(seq)};
            end
            req_valid[i] = r_valid[i];
            req_data[i*RW +: RW] = r_data[i];
        end
        exe_req_ready = ($urandom_range(99) < rdy_pct);
        for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(99) < rsp_pct);
        exe_rsp_valid = 1'b0;
        exe_rsp_data  = '0;
        if (orphan) begin
            exe_rsp_valid = 1'b1;
            exe_rsp_data  = 16'hDEAD;
        end else if (!comb && unit_q.size() > 0 && unit_due[0] <= cyc) begin
            exe_rsp_valid = 1'b1;
            exe_rsp_data  = unit_q[0];
        end
        #1;
        if (comb) begin
            exe_rsp_valid = exe_req_valid && exe_req_ready;
            exe_rsp_data  = rsp_of(exe_req_data);
            #1;
        end

        // expected behaviour from the arbitration and routing rules
        pre_n = m_order.size();
        g     = m_locked ? m_lock_idx : m_rr;
        found = m_locked;
        for (int k = 0; k < N; k++) begin
            if (!found && r_valid[(m_rr + k) % N]) begin
                g     = (m_rr + k) % N;
                found = 1'b1;
            end
        end
        full_e = (pre_n == DEPTH);
        vld_e  = (req_valid != '0) && !full_e;
        check_eq("exe_req_valid", exe_req_valid, vld_e);
        oh = '0;
        if (vld_e && exe_req_ready) oh[g] = 1'b1;
        check_eq("req_ready", req_ready, oh);
        if (vld_e) check_eq("exe_req_data", exe_req_data, r_data[g]);
        route_ok = (pre_n > 0) || vld_e;
        route    = (pre_n > 0) ? m_order[0] : g;
        oh = '0;
        if (route_ok && exe_rsp_valid) oh[route] = 1'b1;
        check_eq("rsp_valid", rsp_valid, oh);
        check_eq("exe_rsp_ready", exe_rsp_ready, route_ok && rsp_ready[route]);
        if (exe_rsp_valid) check_eq("rsp_data", rsp_data, exe_rsp_data);
        check_eq("outstanding", outstanding, pre_n);
        check_eq("err", err, m_err);

        req_hs = vld_e && exe_req_ready;
        rsp_hs = route_ok && exe_rsp_valid && rsp_ready[route];
        bypass = (pre_n == 0) && vld_e;

        if (req_hs) begin
            grant_log.push_back(g);
            exp_q.push_back({IW'(g), rsp_of(r_data[g])});
            r_valid[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                got = {IW'(i), rsp_data};
                if (exp_q.size() > 0) want = exp_q.pop_front();
                else want = '1;
                check_eq("sb_rsp", got, want);
            end
        end

        if (!comb) begin
            if (exe_req_valid && exe_req_ready) begin
                unit_q.push_back(rsp_of(exe_req_data));
                unit_due.push_back(cyc + lat);
            end
            if (!orphan && exe_rsp_valid && exe_rsp_ready && unit_q.size() > 0) begin
                void'(unit_q.pop_front());
                void'(unit_due.pop_front());
            end
        end

        if (req_hs) begin
            if (!(bypass && rsp_hs)) m_order.push_back(g);
            m_rr     = (g + 1) % N;
            m_locked = 1'b0;
        end else if (vld_e) begin
            m_locked   = 1'b1;
            m_lock_idx = g;
        end
        if (rsp_hs && pre_n > 0) void'(m_order.pop_front());
        if (exe_rsp_valid && pre_n == 0 && !vld_e) m_err = 1'b1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        req_en  = '0;
        rdy_pct = 100;
        rsp_pct = 100;
        orphan  = 1'b0;
        n = 0;
        while (n < 300 && busy()) begin
            run_cycle();
            n++;
        end
        check_eq("drain_idle", busy(), 0);
    endtask

    task automatic model_reset();
        m_rr = 0; m_locked = 1'b0; m_lock_idx = 0; m_err = 1'b0;
        m_order.delete(); exp_q.delete(); unit_q.delete(); unit_due.delete();
        r_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_data = '0; rsp_ready = '0;
        exe_req_ready = 1'b0; exe_rsp_valid = 1'b0; exe_rsp_data = '0;
        for (int i = 0; i < N; i++) r_data[i] = '0;
        seq = 0; cyc = 0; lat = 2; comb = 1'b0; orphan = 1'b0;
        req_en = '0; req_pct = 0; rdy_pct = 0; rsp_pct = 0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_exe_req_valid", exe_req_valid, 0);
        check_eq("rst_exe_rsp_ready", exe_rsp_ready, 0);
        @(negedge clk);
        rstn = 1'b1;

        // two requesters always valid, combinational unit: grants alternate
        comb = 1'b1; req_en = 3'b011; req_pct = 100; rdy_pct = 100; rsp_pct = 100;
        grant_log.delete();
        repeat (8) run_cycle();
        for (int i = 0; i < 8; i++)
            check_eq("alt_grant", (i < grant_log.size()) ? grant_log[i] : 99, i % 2);
        drain();

        // random traffic against the combinational unit
        req_en = 3'b111; req_pct = 50; rdy_pct = 60; rsp_pct = 100;
        repeat (200) run_cycle();
        drain();

        // back-to-back burst from requester 1 fills the order FIFO
        comb = 1'b0; lat = 2;
        req_en = 3'b010; req_pct = 100; rdy_pct = 100; rsp_pct = 0;
        grant_log.delete();
        repeat (6) run_cycle();
        check_eq("burst_accepted", grant_log.size(), 4);
        check_eq("burst_full", outstanding, 4);
        check_eq("burst_blocked", req_ready, 0);
        drain();

        // grant held on requester 0 while the unit stalls
        grant_log.delete();
        req_en = 3'b001; req_pct = 100; rdy_pct = 100; rsp_pct = 100;
        run_cycle();
        rdy_pct = 0;
        run_cycle();
        req_en = 3'b011;
        repeat (2) begin
            run_cycle();
            check_eq("lock_hold", exe_req_data[15:14], 0);
        end
        rdy_pct = 100;
        repeat (2) run_cycle();
        check_eq("lock_n", grant_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check_eq("lock_grant", (i < grant_log.size()) ? grant_log[i] : 99, (i == 2) ? 1 : 0);
        drain();

        // random traffic with latency and response back-pressure
        for (int l = 1; l <= 3; l += 2) begin
            lat = l;
            req_en = 3'b111; req_pct = 40; rdy_pct = 70; rsp_pct = 70;
            repeat (300) run_cycle();
            drain();
        end

        // orphan response raises a sticky error
        orphan = 1'b1;
        run_cycle();
        orphan = 1'b0;
        run_cycle();
        check_eq("err_set", err, 1);
        repeat (3) run_cycle();
        check_eq("err_sticky", err, 1);

        // asynchronous reset with three requests outstanding
        lat = 50; req_en = 3'b010; req_pct = 100; rdy_pct = 100; rsp_pct = 100;
        repeat (3) run_cycle();
        @(negedge clk);
        check_eq("pre_reset_outstanding", outstanding, 3);
        rstn = 1'b0;
        #1;
        check_eq("async_rst_outstanding", outstanding, 0);
        check_eq("async_rst_err", err, 0);
        model_reset();
        req_valid = '0;
        @(posedge clk);
        #1;
        check_eq("rst_hold_outstanding", outstanding, 0);
        @(negedge clk);
        rstn = 1'b1;
        lat = 2; req_en = 3'b110;
        grant_log.delete();
        run_cycle();
        check_eq("post_rst_n", grant_log.size(), 1);
        check_eq("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : 99, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
